// File: rtl/llr_stage_scheduler.sv
// rtl/llr_stage_scheduler.sv - issue/write-back sequencer for one SC polar decoding stage
// Drives read groups over a shared f/g PE array and replays them as write-backs RD_LAT cycles later.
module llr_stage_scheduler #(
  parameter int N_LOG  = 4,
  parameter int PE_NUM = 4,
  parameter int RD_LAT = 2,
  parameter int SW     = $clog2(N_LOG) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SW-1:0]     stage,
  input  logic              op_g,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [N_LOG-1:0]  rd_idx,
  output logic [PE_NUM-1:0] rd_mask,
  output logic              op_out,
  output logic              wr_en,
  output logic [N_LOG-1:0]  wr_idx,
  output logic [PE_NUM-1:0] wr_mask
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [N_LOG-1:0]  grp_cnt, grp_last, idx_q;
  logic [PE_NUM-1:0] mask_q;
  logic [CW-1:0]     drain_cnt;
  logic              op_q, err_q;

  logic              idle_like, accept, bad_start;
  logic [N_LOG-1:0]  g_last_new;
  logic [PE_NUM-1:0] mask_new;
  int                pairs;

  logic [RD_LAT-1:0] pipe_en;
  logic [N_LOG-1:0]  pipe_idx  [RD_LAT];
  logic [PE_NUM-1:0] pipe_mask [RD_LAT];

  // Group count and lane mask for the requested stage, computed at acceptance.
  always_comb begin
    idle_like  = (state == IDLE) || (state == DONE);
    accept     = idle_like && start && (stage < SW'(N_LOG));
    bad_start  = idle_like && start && (stage >= SW'(N_LOG));
    pairs      = 1 << stage;
    g_last_new = '0;
    mask_new   = '0;
    if (pairs >= PE_NUM) begin
      g_last_new = N_LOG'(pairs / PE_NUM - 1);
      mask_new   = '1;
    end else begin
      for (int l = 0; l < PE_NUM; l++) mask_new[l] = (l < pairs);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      ISSUE: if (grp_cnt == grp_last) state_nx = DRAIN;
      // Last read is already in the pipe; DRAIN spans exactly RD_LAT cycles.
      DRAIN: if (drain_cnt == CW'(RD_LAT - 1)) state_nx = DONE;
      DONE:  state_nx = accept ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ISSUE) || (state == DRAIN);
    done    = (state == DONE);
    err     = err_q;
    rd_en   = (state == ISSUE);
    rd_idx  = rd_en ? idx_q : '0;
    rd_mask = rd_en ? mask_q : '0;
    op_out  = op_q;
    wr_en   = pipe_en[RD_LAT-1];
    wr_idx  = pipe_idx[RD_LAT-1];
    wr_mask = pipe_mask[RD_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grp_cnt   <= '0;
      grp_last  <= '0;
      idx_q     <= '0;
      mask_q    <= '0;
      drain_cnt <= '0;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      pipe_en   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_idx[i]  <= '0;
        pipe_mask[i] <= '0;
      end
    end else begin
      state <= state_nx;
      err_q <= bad_start;
      if (accept) begin
        grp_cnt  <= '0;
        grp_last <= g_last_new;
        idx_q    <= '0;
        mask_q   <= mask_new;
        op_q     <= op_g;
      end else if (state == ISSUE) begin
        grp_cnt <= grp_cnt + N_LOG'(1);
        idx_q   <= idx_q + N_LOG'(PE_NUM);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
        pipe_mask[i] <= pipe_mask[i-1];
      end
      pipe_en[0]   <= rd_en;
      pipe_idx[0]  <= rd_idx;
      pipe_mask[0] <= rd_mask;
    end
  end

endmodule

// File: tb/tb_llr_stage_scheduler.sv
// tb/tb_llr_stage_scheduler.sv - directed self-checking bench for llr_stage_scheduler
module tb_llr_stage_scheduler;

  localparam int N_LOG  = 4;
  localparam int PE_NUM = 4;
  localparam int RD_LAT = 2;
  localparam int SW     = 3;

  logic              clk = 1'b0;
  logic              rst, start, op_g;
  logic [SW-1:0]     stage;
  logic              busy, done, err, rd_en, op_out, wr_en;
  logic [N_LOG-1:0]  rd_idx, wr_idx;
  logic [PE_NUM-1:0] rd_mask, wr_mask;

  llr_stage_scheduler #(.N_LOG(N_LOG), .PE_NUM(PE_NUM), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .op_g(op_g),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_mask(rd_mask), .op_out(op_out),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_mask(wr_mask)
  );

  always #5 clk = ~clk;

  // {rd_en, rd_idx, rd_mask, wr_en, wr_idx, wr_mask, done, busy, err, op_out}
  typedef logic [21:0] vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t cap [0:15];

  function automatic vec_t obs();
    return {rd_en, rd_idx, rd_mask, wr_en, wr_idx, wr_mask, done, busy, err, op_out};
  endfunction

  // Expected outputs in cycle c after a start accepted with g groups and lane mask m.
  function automatic vec_t model(input int c, input int g, input logic [3:0] m, input logic op);
    logic       r, w, d, b;
    logic [3:0] ri, wi, rm, wm;
    r  = (c >= 1) && (c <= g);
    w  = (c >= 1 + RD_LAT) && (c <= g + RD_LAT);
    d  = (c == g + RD_LAT + 1);
    b  = (c >= 1) && (c <= g + RD_LAT);
    ri = r ? 4'((c - 1) * PE_NUM) : 4'd0;
    wi = w ? 4'((c - 1 - RD_LAT) * PE_NUM) : 4'd0;
    rm = r ? m : 4'd0;
    wm = w ? m : 4'd0;
    return {r, ri, rm, w, wi, wm, d, b, 1'b0, op};
  endfunction

  task automatic launch(input int s, input logic g);
    @(negedge clk);
    stage = SW'(s);
    op_g  = g;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      cap[c] = obs();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stage = '0; op_g = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs() !== 22'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", obs(), 22'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== 22'h0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h exp=%h", obs(), 22'h0);
    end
  endtask

  task automatic test_f_stage3();
    vec_t e;
    launch(3, 1'b0);
    capture(7);
    for (int c = 1; c <= 7; c++) begin
      e = model(c, 2, 4'b1111, 1'b0);
      total++;
      if (cap[c] !== e) begin
        bad++;
        $display("FAIL f_stage3 cyc=%0d got=%h exp=%h", c, cap[c], e);
      end
    end
  endtask

  task automatic test_g_stage1();
    vec_t e;
    launch(1, 1'b1);
    capture(6);
    for (int c = 1; c <= 6; c++) begin
      e = model(c, 1, 4'b0011, 1'b1);
      total++;
      if (cap[c] !== e) begin
        bad++;
        $display("FAIL g_stage1 cyc=%0d got=%h exp=%h", c, cap[c], e);
      end
    end
  endtask

  task automatic test_small_stages();
    vec_t e;
    launch(0, 1'b0);
    capture(6);
    for (int c = 1; c <= 6; c++) begin
      e = model(c, 1, 4'b0001, 1'b0);
      total++;
      if (cap[c] !== e) begin
        bad++;
        $display("FAIL stage0 cyc=%0d got=%h exp=%h", c, cap[c], e);
      end
    end
    launch(2, 1'b1);
    capture(6);
    for (int c = 1; c <= 6; c++) begin
      e = model(c, 1, 4'b1111, 1'b1);
      total++;
      if (cap[c] !== e) begin
        bad++;
        $display("FAIL stage2 cyc=%0d got=%h exp=%h", c, cap[c], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t e;
    launch(3, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cap[c] = obs();
      start  = (c >= 2) && (c <= 5);
      stage  = 3'd1;
      op_g   = 1'b1;
    end
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      e = (c <= 5) ? model(c, 2, 4'b1111, 1'b0) : model(c - 5, 1, 4'b0011, 1'b1);
      total++;
      if (cap[c] !== e) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, cap[c], e);
      end
    end
  endtask

  task automatic test_reset_abort();
    launch(3, 1'b1);
    @(negedge clk);
    total++;
    if (rd_en !== 1'b1 || op_out !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_rd got=%b%b exp=11", rd_en, op_out);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (obs() !== 22'h0) begin
        bad++;
        $display("FAIL abort_quiet cyc=%0d got=%h exp=%h", c, obs(), 22'h0);
      end
    end
    test_f_stage3();
  endtask

  task automatic test_bad_stage();
    vec_t e;
    for (int k = 0; k < 2; k++) begin
      launch(k == 0 ? 4 : 7, k[0]);
      capture(4);
      for (int c = 1; c <= 4; c++) begin
        e = (c == 1) ? 22'h2 : 22'h0;
        total++;
        if (cap[c] !== e) begin
          bad++;
          $display("FAIL bad_stage k=%0d cyc=%0d got=%h exp=%h", k, c, cap[c], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_f_stage3();
    test_g_stage1();
    test_small_stages();
    test_back_to_back();
    test_reset_abort();
    test_bad_stage();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
